sdrd_byte_rx: RTL

Serial-to-parallel receive stage directly downstream of the registered serial-data state machine. It samples the SDRD bit stream on qualified bus-write cycles, hunts for a 16-bit sync word, then assembles MSB-first bytes for a fixed-length frame. Assembled bytes go into a small FIFO that the host reads through a pop strobe.

---
 rtl/sdrd_pkg.sv | 12 +
 rtl/sdrd_byte_rx_if.sv | 25 ++
 rtl/sdrd_byte_fifo.sv | 52 +++++
 rtl/sdrd_byte_rx.sv | 109 ++++++++++
 4 files changed

// File: rtl/sdrd_pkg.sv
// Shared types and constants for the SDRD byte receive path.
package sdrd_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        DATA = 1'b1
    } rx_state_t;

    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'h4489;
    localparam int unsigned BYTE_W            = 8;

endpackage

// File: rtl/sdrd_byte_rx_if.sv
// Bit-stream input, host pop/clear strobes and receive status outputs.
interface sdrd_byte_rx_if;
    import sdrd_pkg::*;

    logic              bit_vld;
    logic              sdrd;
    logic              rd_pop;
    logic              clr_ovr;
    logic [BYTE_W-1:0] rd_data;
    logic              rd_avail;
    logic              in_sync;
    logic              overrun;
    logic              frame_done;

    modport master (
        output bit_vld, sdrd, rd_pop, clr_ovr,
        input  rd_data, rd_avail, in_sync, overrun, frame_done
    );

    modport slave (
        input  bit_vld, sdrd, rd_pop, clr_ovr,
        output rd_data, rd_avail, in_sync, overrun, frame_done
    );

endinterface

// File: rtl/sdrd_byte_fifo.sv
// Small synchronous byte FIFO; a push into a full FIFO is dropped and flagged.
module sdrd_byte_fifo
    import sdrd_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = BYTE_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         drop_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && full_o && !pop_i;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Pointer and storage update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= din_i;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdrd_byte_rx.sv
// Sync-word hunt and MSB-first byte assembly feeding a byte FIFO.
module sdrd_byte_rx
    import sdrd_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD  = SYNC_WORD_DEFAULT,
    parameter int unsigned FRAME_LEN  = 256,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic           clk,
    input logic           rst_n,
    sdrd_byte_rx_if.slave bus
);
    localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

    rx_state_t         state_q;
    logic [15:0]       win_q, win_d;
    logic [7:0]        sh_q, sh_d;
    logic [2:0]        bit_cnt_q;
    logic [15:0]       byte_cnt_q;
    logic              in_sync_q, frame_done_q, ovr_q;
    logic              push;
    logic              fifo_full, fifo_empty, fifo_drop;
    logic [BYTE_W-1:0] fifo_dout;

    assign win_d = {win_q[14:0], bus.sdrd};
    assign sh_d  = {sh_q[6:0], bus.sdrd};
    assign push  = (state_q == DATA) && bus.bit_vld && (bit_cnt_q == 3'd7);

    sdrd_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (BYTE_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (sh_d),
        .pop_i   (bus.rd_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop)
    );

    // Hunt/data state machine with its counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            win_q        <= '0;
            sh_q         <= '0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            in_sync_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                HUNT: begin
                    if (bus.bit_vld) begin
                        win_q <= win_d;
                        if (win_d == SYNC_WORD) begin
                            state_q    <= DATA;
                            in_sync_q  <= 1'b1;
                            bit_cnt_q  <= '0;
                            byte_cnt_q <= '0;
                        end
                    end
                end
                DATA: begin
                    if (bus.bit_vld) begin
                        sh_q      <= sh_d;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (byte_cnt_q == LAST_IDX) begin
                                frame_done_q <= 1'b1;
                                state_q      <= HUNT;
                                in_sync_q    <= 1'b0;
                                win_q        <= '0;
                            end else begin
                                byte_cnt_q <= byte_cnt_q + 16'd1;
                            end
                        end
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    // Sticky overrun: a drop wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= 1'b0;
        end else if (fifo_drop) begin
            ovr_q <= 1'b1;
        end else if (bus.clr_ovr) begin
            ovr_q <= 1'b0;
        end
    end

    a_drop_only_when_full : assert property (@(posedge clk) disable iff (!rst_n)
        fifo_drop |-> fifo_full);

    assign bus.rd_data    = fifo_dout;
    assign bus.rd_avail   = !fifo_empty;
    assign bus.in_sync    = in_sync_q;
    assign bus.overrun    = ovr_q;
    assign bus.frame_done = frame_done_q;

endmodule
